serial_word_adder: RTL and testbench

Parametrised successor of the 1-bit serial adder. Adds or subtracts two operands presented LSB-first, DIGIT_W bits per beat, framed into words of WORD_DIGITS beats, with a valid qualifier and registered outputs. Reports carry/borrow at the end of each word, and optionally signed overflow. Sits in the sequential-basics datapath as the multi-bit, multi-word serial arithmetic unit.

---
 rtl/serial_word_adder.sv | 114 +++++++++++
 tb/tb_serial_word_adder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_adder.sv
// Serial add/subtract of LSB-first words, DIGIT_W bits per beat, WORD_DIGITS beats per word.
// Define SERIAL_WORD_ADDER_OVERFLOW_EN to add the registered signed-overflow output.
module serial_word_adder #(
  parameter int unsigned DIGIT_W     = 1,
  parameter int unsigned WORD_DIGITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               sub,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               out_valid,
  output logic [DIGIT_W-1:0] sum,
  output logic               out_last,
  output logic               carry_out
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
  ,
  output logic               overflow
`endif
);

  localparam int unsigned    CNT_W    = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_DIGITS - 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               sub_r_q, sub_r_d;
  logic               out_valid_q, out_valid_d;
  logic [DIGIT_W-1:0] sum_q, sum_d;
  logic               out_last_q, out_last_d;
  logic               carry_out_q, carry_out_d;
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
  logic               overflow_q, overflow_d;
`endif

  logic               first_beat;
  logic               last_beat;
  logic               mode;
  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W-1:0] chain_sum;
  logic [DIGIT_W:0]   chain_c;

  // The first beat of a word takes mode and carry-in straight from sub so
  // that words can run back-to-back without a stale carry leaking across.
  always_comb begin
    first_beat = (cnt_q == '0);
    last_beat  = (cnt_q == CNT_LAST);
    mode       = first_beat ? sub : sub_r_q;
    b_eff      = b ^ {DIGIT_W{mode}};
    chain_sum  = '0;
    chain_c    = '0;
    chain_c[0] = first_beat ? sub : carry_q;
    for (int i = 0; i < DIGIT_W; i++) begin
      chain_sum[i]   = a[i] ^ b_eff[i] ^ chain_c[i];
      chain_c[i+1]   = (a[i] & b_eff[i]) | (chain_c[i] & (a[i] ^ b_eff[i]));
    end
  end

  always_comb begin
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    sub_r_d     = sub_r_q;
    if (in_valid) begin
      carry_d = chain_c[DIGIT_W];
      if (first_beat) begin
        sub_r_d = sub;
      end
      cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
    end
    out_valid_d = in_valid;
    sum_d       = in_valid ? chain_sum : '0;
    out_last_d  = in_valid && last_beat;
    carry_out_d = (in_valid && last_beat) ? chain_c[DIGIT_W] : 1'b0;
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
    overflow_d  = (in_valid && last_beat) ? (chain_c[DIGIT_W] ^ chain_c[DIGIT_W-1]) : 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sub_r_q     <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      out_last_q  <= 1'b0;
      carry_out_q <= 1'b0;
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
      overflow_q  <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      sub_r_q     <= sub_r_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      out_last_q  <= out_last_d;
      carry_out_q <= carry_out_d;
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
      overflow_q  <= overflow_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign out_last  = out_last_q;
  assign carry_out = carry_out_q;
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
  assign overflow  = overflow_q;
`endif

endmodule

// File: tb/tb_serial_word_adder.sv
// Directed bench for serial_word_adder in three shapes: 1x8, 4x2 and 8x1 (digit width x beats).
module tb_serial_word_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       va, sa, aa, ba;
  logic       ova, suma, la, ca;
  logic       vb, sb;
  logic [3:0] ab, bb, sumb;
  logic       ovb, lb, cb;
  logic       vc, sc;
  logic [7:0] ac, bc, sumc;
  logic       ovc, lc, cc;
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
  logic       ofa, ofb, ofc;
`endif

  int n_vec = 0;
  int n_err = 0;

  serial_word_adder #(.DIGIT_W(1), .WORD_DIGITS(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(va), .sub(sa), .a(aa), .b(ba),
    .out_valid(ova), .sum(suma), .out_last(la), .carry_out(ca)
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
    , .overflow(ofa)
`endif
  );

  serial_word_adder #(.DIGIT_W(4), .WORD_DIGITS(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(vb), .sub(sb), .a(ab), .b(bb),
    .out_valid(ovb), .sum(sumb), .out_last(lb), .carry_out(cb)
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
    , .overflow(ofb)
`endif
  );

  serial_word_adder #(.DIGIT_W(8), .WORD_DIGITS(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(vc), .sub(sc), .a(ac), .b(bc),
    .out_valid(ovc), .sum(sumc), .out_last(lc), .carry_out(cc)
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
    , .overflow(ofc)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk1({tag, ".a_valid"}, ova, 1'b0);
    chk1({tag, ".a_sum"}, suma, 1'b0);
    chk1({tag, ".a_last"}, la, 1'b0);
    chk1({tag, ".a_carry"}, ca, 1'b0);
    chk1({tag, ".b_valid"}, ovb, 1'b0);
    chk8({tag, ".b_sum"}, {4'h0, sumb}, 8'h00);
    chk1({tag, ".b_last"}, lb, 1'b0);
    chk1({tag, ".b_carry"}, cb, 1'b0);
    chk1({tag, ".c_valid"}, ovc, 1'b0);
    chk8({tag, ".c_sum"}, sumc, 8'h00);
    chk1({tag, ".c_carry"}, cc, 1'b0);
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
    chk1({tag, ".a_ovf"}, ofa, 1'b0);
    chk1({tag, ".b_ovf"}, ofb, 1'b0);
    chk1({tag, ".c_ovf"}, ofc, 1'b0);
`endif
  endtask

  // One 8-beat word on u_a; sub_later drives sub on beats 2..8, and
  // gap_len idle cycles with garbage operands follow beat gap_after+1.
  task automatic word_a(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic s, input logic sub_later, input int gap_after,
                        input int gap_len, input logic [7:0] exp_sum,
                        input logic exp_c, input logic exp_o);
    logic [7:0] got;
    got = 8'h00;
    for (int i = 0; i < 8; i++) begin
      va = 1'b1;
      sa = (i == 0) ? s : sub_later;
      aa = x[i];
      ba = y[i];
      tick();
      chk1({tag, ".valid"}, ova, 1'b1);
      chk1({tag, ".last"}, la, (i == 7));
      chk1({tag, ".carry"}, ca, (i == 7) ? exp_c : 1'b0);
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
      chk1({tag, ".ovf"}, ofa, (i == 7) ? exp_o : 1'b0);
`else
      if (exp_o === 1'bx) $display("unreachable");
`endif
      got[i] = suma;
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          va = 1'b0;
          sa = 1'b1;
          aa = 1'b1;
          ba = 1'b1;
          tick();
          chk1({tag, ".gap_valid"}, ova, 1'b0);
          chk1({tag, ".gap_sum"}, suma, 1'b0);
          chk1({tag, ".gap_last"}, la, 1'b0);
          chk1({tag, ".gap_carry"}, ca, 1'b0);
        end
      end
    end
    va = 1'b0;
    sa = 1'b0;
    aa = 1'b0;
    ba = 1'b0;
    chk8({tag, ".word"}, got, exp_sum);
  endtask

  task automatic word_b(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic s, input logic [7:0] exp_sum,
                        input logic exp_c, input logic exp_o);
    vb = 1'b1;
    sb = s;
    ab = x[3:0];
    bb = y[3:0];
    tick();
    chk1({tag, ".d0_valid"}, ovb, 1'b1);
    chk8({tag, ".d0_sum"}, {4'h0, sumb}, {4'h0, exp_sum[3:0]});
    chk1({tag, ".d0_last"}, lb, 1'b0);
    chk1({tag, ".d0_carry"}, cb, 1'b0);
    sb = ~s;
    ab = x[7:4];
    bb = y[7:4];
    tick();
    chk8({tag, ".d1_sum"}, {4'h0, sumb}, {4'h0, exp_sum[7:4]});
    chk1({tag, ".d1_last"}, lb, 1'b1);
    chk1({tag, ".d1_carry"}, cb, exp_c);
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
    chk1({tag, ".d1_ovf"}, ofb, exp_o);
`else
    if (exp_o === 1'bx) $display("unreachable");
`endif
    vb = 1'b0;
    sb = 1'b0;
    ab = 4'h0;
    bb = 4'h0;
  endtask

  task automatic word_c(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic s, input logic [7:0] exp_sum,
                        input logic exp_c, input logic exp_o);
    vc = 1'b1;
    sc = s;
    ac = x;
    bc = y;
    tick();
    chk1({tag, ".valid"}, ovc, 1'b1);
    chk8({tag, ".sum"}, sumc, exp_sum);
    chk1({tag, ".last"}, lc, 1'b1);
    chk1({tag, ".carry"}, cc, exp_c);
`ifdef SERIAL_WORD_ADDER_OVERFLOW_EN
    chk1({tag, ".ovf"}, ofc, exp_o);
`else
    if (exp_o === 1'bx) $display("unreachable");
`endif
    vc = 1'b0;
    sc = 1'b0;
    ac = 8'h00;
    bc = 8'h00;
  endtask

  initial begin
    rst = 1'b0;
    va = 1'b0; sa = 1'b0; aa = 1'b0; ba = 1'b0;
    vb = 1'b0; sb = 1'b0; ab = 4'h0; bb = 4'h0;
    vc = 1'b0; sc = 1'b0; ac = 8'h00; bc = 8'h00;
    tick();
    tick();
    all_zero("reset");
    rst = 1'b1;

    word_a("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, -1, 0, 8'h96, 1'b0, 1'b1);
    word_a("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b1, -1, 0, 8'hF0, 1'b0, 1'b0);
    word_a("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, -1, 0, 8'h00, 1'b1, 1'b0);
    tick();
    word_a("gap_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 3, 3, 8'h00, 1'b1, 1'b0);
    word_a("sub_toggle", 8'h5A, 8'h3C, 1'b0, 1'b1, -1, 0, 8'h96, 1'b0, 1'b1);

    for (int i = 0; i < 3; i++) begin
      va = 1'b1; sa = 1'b1; aa = 1'b1; ba = 1'b0;
      tick();
    end
    rst = 1'b0;
    tick();
    all_zero("mid_reset");
    rst = 1'b1;
    word_a("after_reset", 8'h01, 8'h01, 1'b0, 1'b0, -1, 0, 8'h02, 1'b0, 1'b0);

    word_b("d4_add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    word_b("d4_sub_3c_5a", 8'h3C, 8'h5A, 1'b1, 8'hE2, 1'b0, 1'b0);
    word_b("d4_sub_5a_3c", 8'h5A, 8'h3C, 1'b1, 8'h1E, 1'b1, 1'b0);

    word_c("w1_add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    word_c("w1_sub_05_03", 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0);
    word_c("w1_add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    tick();
    all_zero("idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

endmodule
